pipe_sched: RTL and testbench
=============================

PIPE_SCHED -- requirements
Module: pipe_sched

Interface
REQ-001 The block SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 idrs, idrt  in  5 each  source registers of the instruction in ID.
REQ-005 idusers, iduserst  in  1 each  ID instruction reads rs / rt.
REQ-006 idwritereg  in  1, iddest  in  5  ID instruction writes register iddest (already resolved from selregdest).
REQ-007 idreadmem, idwritemem  in  1 each  ID instruction is LW / SW.
REQ-008 brtaken  in  1  branch/jump in EX resolved taken this cycle.
REQ-009 imemready  in  1  instruction fetch completes this cycle.
REQ-010 memready  in  1  data-memory access completes this cycle.
REQ-011 stallif, stallid  out  1 each  hold PC / hold IF-ID register.
REQ-012 bubbleex  out  1  load NOP control word into ID-EX.
REQ-013 flushid  out  1  replace IF-ID contents with NOP.
REQ-014 memreq  out  1  data-memory request for the MEM-stage instruction.
REQ-015 fwda, fwdb  out  2 each  EX operand A/B source: 00 register file, 01 MEM-stage result, 10 WB-stage result.
REQ-016 freeze  out  1  hold ID-EX, EX-MEM, MEM-WB registers.
REQ-017 stallcnt  out  16  saturating count of cycles with stallif high.

Function
REQ-018 The block SHALL keep shadow records {valid, writereg, dest, readmem, writemem, rs, rt} for EX, MEM and WB, advancing ID->EX->MEM->WB on every edge where freeze is low.
REQ-019 A bubble or flush SHALL load a record with valid=0 into EX.
REQ-020 FSM states RUN, MEMWAIT; RUN->MEMWAIT when memreq=1 and memready=0; MEMWAIT->RUN on memready=1; no other transitions.
REQ-021 memreq SHALL equal MEM.valid & (MEM.readmem | MEM.writemem), held high until the cycle memready=1.
REQ-022 freeze = memreq & ~memready; while freeze=1, stallif=stallid=1, bubbleex=0, flushid=0 and no shadow record changes.
REQ-023 Load-use: EX.valid & EX.readmem & EX.writereg & EX.dest!=0 & ((idusers & EX.dest==idrs) | (iduserst & EX.dest==idrt)) SHALL give stallif=stallid=bubbleex=1 for exactly one cycle.
REQ-024 brtaken=1 (freeze=0) SHALL give flushid=1, bubbleex=1, stallif=0 and SHALL suppress load-use stall that cycle.
REQ-025 imemready=0 (no freeze, no brtaken, no load-use) SHALL give stallif=stallid=1, bubbleex=1.
REQ-026 Priority: freeze > brtaken > load-use > imemready stall.
REQ-027 fwda SHALL be 01 if MEM.valid & MEM.writereg & MEM.dest!=0 & MEM.dest==EX.rs, else 10 if the same holds for WB, else 00; fwdb identical using EX.rt.
REQ-028 Register 0 SHALL never cause a stall or forward.
REQ-029 A load in MEM SHALL NOT be forwarded from MEM (its data arrives in WB); load-use stall guarantees WB forwarding.
REQ-030 stallcnt SHALL increment on every cycle with stallif=1 and saturate at 16'hFFFF.
REQ-031 All outputs except stallcnt, and the registers behind fwda/fwdb, SHALL be combinational from current shadow state and inputs (zero-cycle latency).

Reset
REQ-032 resetn=0 SHALL asynchronously set state=RUN, all valid bits 0, stallcnt=0.
REQ-033 Hence during and after reset: stallif=stallid=bubbleex=flushid=memreq=freeze=0, fwda=fwdb=00.
REQ-034 Reset asserted mid-MEMWAIT SHALL abandon the access; memreq low in the same cycle.

Structure
REQ-035 Package pipe_pkg SHALL hold state encoding (RUN, MEMWAIT), FWD_REG=00, FWD_MEM=01, FWD_WB=10, and the shadow-record field widths.
REQ-036 One sub-module pipe_fwd (combinational comparator producing one 2-bit select) SHALL be instantiated twice, for fwda and fwdb.

Verification
REQ-037 LW $2 in EX, ID ADD $3,$2,$4 -> one cycle stallif=stallid=bubbleex=1; next cycle ADD in EX with fwda=10.
REQ-038 ADD $5 in MEM and SUB $5 in WB, EX reads rs=$5 -> fwda=01 (MEM wins); dest $0 in MEM -> fwda=00.
REQ-039 SW in MEM, memready low 3 cycles -> memreq=1 and freeze=1 for 3 cycles, state MEMWAIT, records unchanged; advance on 4th edge.
REQ-040 brtaken=1 coincident with load-use hazard -> flushid=1, bubbleex=1, stallif=0, no stall next cycle.
REQ-041 imemready=0 for 2 cycles from reset -> stallcnt=2; force 70000 stall cycles -> stallcnt=16'hFFFF.
REQ-042 resetn low during MEMWAIT -> memreq=0, freeze=0, fwda=fwdb=00 immediately, state RUN.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared definitions for the pipeline hazard scheduler.
//   state_t  : scheduler FSM states (RUN, MEMWAIT)
//   FWD_*    : EX operand source select encodings
//   rec_t    : shadow record tracking one instruction through EX/MEM/WB
//   produces : true when a record will write a real (non-zero) register
package pipe_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic             valid;
    logic             writereg;
    logic [REG_W-1:0] dest;
    logic             readmem;
    logic             writemem;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
  } rec_t;

  localparam rec_t REC_NOP = '0;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  function automatic logic produces(input rec_t r);
    return r.valid & r.writereg & (r.dest != '0);
  endfunction

endpackage

// File: rtl/pipe_fwd.sv
// pipe_fwd -- forwarding select for one EX source operand.
//   src                      : register number read by the EX instruction
//   mem_valid/writereg/readmem/dest : MEM-stage shadow record fields
//   wb_valid/writereg/dest   : WB-stage shadow record fields
//   sel                      : FWD_MEM, FWD_WB or FWD_REG (purely combinational)
module pipe_fwd
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             mem_valid,
  input  logic             mem_writereg,
  input  logic             mem_readmem,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             wb_valid,
  input  logic             wb_writereg,
  input  logic [REG_W-1:0] wb_dest,
  output logic [1:0]       sel
);

  logic mem_hit;
  logic wb_hit;

  // A load in MEM has no data yet; its value only exists once it reaches WB.
  assign mem_hit = mem_valid & mem_writereg & ~mem_readmem &
                   (mem_dest != '0) & (mem_dest == src);
  assign wb_hit  = wb_valid & wb_writereg & (wb_dest != '0) & (wb_dest == src);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel = FWD_REG;
    if (mem_hit)     sel = FWD_MEM;  // youngest producer wins
    else if (wb_hit) sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_sched.sv
// pipe_sched -- hazard detection, stall/flush control and operand forwarding
// for a 5-stage in-order pipeline.
//   clock, resetn                 : rising-edge clock, async active-low reset
//   idrs/idrt/idusers/iduserst    : ID-stage source registers and use flags
//   idwritereg/iddest             : ID-stage destination
//   idreadmem/idwritemem          : ID instruction is a load / store
//   brtaken                       : branch/jump in EX resolved taken
//   imemready/memready            : instruction / data memory completion
//   stallif/stallid/bubbleex/flushid : pipeline register controls
//   memreq/freeze                 : data-memory request and back-end hold
//   fwda/fwdb                     : EX operand source selects
//   stallcnt                      : saturating count of stallif cycles
module pipe_sched
  import pipe_pkg::*;
(
  input  logic             clock,
  input  logic             resetn,
  input  logic [REG_W-1:0] idrs,
  input  logic [REG_W-1:0] idrt,
  input  logic             idusers,
  input  logic             iduserst,
  input  logic             idwritereg,
  input  logic [REG_W-1:0] iddest,
  input  logic             idreadmem,
  input  logic             idwritemem,
  input  logic             brtaken,
  input  logic             imemready,
  input  logic             memready,
  output logic             stallif,
  output logic             stallid,
  output logic             bubbleex,
  output logic             flushid,
  output logic             memreq,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             freeze,
  output logic [CNT_W-1:0] stallcnt
);

  state_t state;
  rec_t   ex_q, mem_q, wb_q;
  rec_t   id_rec;
  logic   loaduse;

  always_comb begin
    id_rec          = REC_NOP;
    id_rec.valid    = 1'b1;
    id_rec.writereg = idwritereg;
    id_rec.dest     = iddest;
    id_rec.readmem  = idreadmem;
    id_rec.writemem = idwritemem;
    id_rec.rs       = idrs;
    id_rec.rt       = idrt;
  end

  // The MEM record is frozen while the access is outstanding, so memreq stays
  // high until the cycle memready arrives.
  assign memreq = mem_q.valid & (mem_q.readmem | mem_q.writemem);
  assign freeze = memreq & ~memready;

  assign loaduse = produces(ex_q) & ex_q.readmem &
                   ((idusers  & (ex_q.dest == idrs)) |
                    (iduserst & (ex_q.dest == idrt)));

  // Priority: freeze > taken branch > load-use > fetch miss.
  always_comb begin
    stallif  = 1'b0;
    stallid  = 1'b0;
    bubbleex = 1'b0;
    flushid  = 1'b0;
    if (freeze) begin
      stallif = 1'b1;
      stallid = 1'b1;
    end else if (brtaken) begin
      flushid  = 1'b1;
      bubbleex = 1'b1;
    end else if (loaduse || !imemready) begin
      stallif  = 1'b1;
      stallid  = 1'b1;
      bubbleex = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the EX->MEM->WB shift happens in parallel.
  // NOTE: whole records are cleared on reset even though only valid matters,
  // keeping post-reset contents deterministic at negligible cost.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
      ex_q  <= REC_NOP;
      mem_q <= REC_NOP;
      wb_q  <= REC_NOP;
    end else begin
      case (state)
        RUN:     if (memreq && !memready) state <= MEMWAIT;
        MEMWAIT: if (memready)            state <= RUN;
        default:                          state <= RUN;
      endcase
      if (!freeze) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= bubbleex ? REC_NOP : id_rec;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stallcnt <= '0;
    end else if (stallif && (stallcnt != '1)) begin
      stallcnt <= stallcnt + CNT_W'(1);
    end
  end

  pipe_fwd u_fwda (
    .src          (ex_q.rs),
    .mem_valid    (mem_q.valid),
    .mem_writereg (mem_q.writereg),
    .mem_readmem  (mem_q.readmem),
    .mem_dest     (mem_q.dest),
    .wb_valid     (wb_q.valid),
    .wb_writereg  (wb_q.writereg),
    .wb_dest      (wb_q.dest),
    .sel          (fwda)
  );

  pipe_fwd u_fwdb (
    .src          (ex_q.rt),
    .mem_valid    (mem_q.valid),
    .mem_writereg (mem_q.writereg),
    .mem_readmem  (mem_q.readmem),
    .mem_dest     (mem_q.dest),
    .wb_valid     (wb_q.valid),
    .wb_writereg  (wb_q.writereg),
    .wb_dest      (wb_q.dest),
    .sel          (fwdb)
  );

  // Record fields carried for completeness but not consumed by any stage logic.
  logic unused_fields;
  assign unused_fields = ^{ex_q.writemem, mem_q.rs, mem_q.rt,
                           wb_q.readmem, wb_q.writemem, wb_q.rs, wb_q.rt};

endmodule

// File: tb/tb_pipe_sched.sv
// tb_pipe_sched -- directed scenarios plus a randomized run checked against
// an instruction-level reference model of the scheduling rules.
module tb_pipe_sched;
  import pipe_pkg::*;

  logic       clock = 1'b0;
  logic       resetn;
  logic [4:0] idrs, idrt, iddest;
  logic       idusers, iduserst, idwritereg, idreadmem, idwritemem;
  logic       brtaken, imemready, memready;
  logic       stallif, stallid, bubbleex, flushid, memreq, freeze;
  logic [1:0] fwda, fwdb;
  logic [15:0] stallcnt;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipe_sched dut (
    .clock(clock), .resetn(resetn),
    .idrs(idrs), .idrt(idrt), .idusers(idusers), .iduserst(iduserst),
    .idwritereg(idwritereg), .iddest(iddest),
    .idreadmem(idreadmem), .idwritemem(idwritemem),
    .brtaken(brtaken), .imemready(imemready), .memready(memready),
    .stallif(stallif), .stallid(stallid), .bubbleex(bubbleex),
    .flushid(flushid), .memreq(memreq), .fwda(fwda), .fwdb(fwdb),
    .freeze(freeze), .stallcnt(stallcnt)
  );

  // ---------------- reference model: instructions moving through stages
  typedef struct {
    bit       v, wr, rd, wm;
    bit [4:0] d, rs, rt;
  } minst_t;

  minst_t     stg[3];           // 0 = EX, 1 = MEM, 2 = WB
  int         mcnt;
  bit         mwait;
  bit         e_si, e_sd, e_bub, e_fl, e_memreq, e_freeze;
  bit   [1:0] e_fwda, e_fwdb;

  function automatic bit [1:0] src_of(input bit [4:0] r);
    if (r == 0) return 2'b00;
    if (stg[1].v && stg[1].wr && !stg[1].rd && stg[1].d == r) return 2'b01;
    if (stg[2].v && stg[2].wr && stg[2].d == r) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) stg[k] = '{default: 0};
    mcnt  = 0;
    mwait = 0;
  endfunction

  function automatic void model_eval();
    bit hazard;
    e_memreq = stg[0].v ? 1'b0 : 1'b0;
    e_memreq = stg[1].v && (stg[1].rd || stg[1].wm);
    e_freeze = e_memreq && !memready;
    hazard   = stg[0].v && stg[0].rd && stg[0].wr && stg[0].d != 0 &&
               ((idusers && idrs == stg[0].d) || (iduserst && idrt == stg[0].d));
    {e_si, e_sd, e_bub, e_fl} = 4'b0000;
    if (e_freeze)                     {e_si, e_sd} = 2'b11;
    else if (brtaken)                 {e_bub, e_fl} = 2'b11;
    else if (hazard || !imemready)    {e_si, e_sd, e_bub} = 3'b111;
    e_fwda = src_of(stg[0].rs);
    e_fwdb = src_of(stg[0].rt);
  endfunction

  function automatic void model_clock();
    minst_t id;
    id = '{v: 1, wr: idwritereg, rd: idreadmem, wm: idwritemem,
           d: iddest, rs: idrs, rt: idrt};
    if (!e_freeze) begin
      stg[2] = stg[1];
      stg[1] = stg[0];
      stg[0] = e_bub ? '{default: 0} : id;
    end
    if (e_si && mcnt != 16'hFFFF) mcnt++;
    mwait = e_freeze;
  endfunction

  // ---------------- stimulus helpers
  task automatic set_id(input bit [4:0] rs, input bit [4:0] rt, input bit us,
                        input bit ut, input bit wr, input bit [4:0] dest,
                        input bit rd, input bit wm);
    idrs = rs; idrt = rt; idusers = us; iduserst = ut;
    idwritereg = wr; iddest = dest; idreadmem = rd; idwritemem = wm;
  endtask

  task automatic set_nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input bit [4:0] rs, input bit [4:0] rt, input bit us,
                      input bit ut, input bit wr, input bit [4:0] dest,
                      input bit rd, input bit wm);
    set_id(rs, rt, us, ut, wr, dest, rd, wm);
    #1;
    next();
  endtask

  task automatic do_reset();
    set_nop();
    brtaken = 0; imemready = 1; memready = 1;
    resetn = 0;
    next();
    resetn = 1;
    model_reset();
  endtask

  // ---------------- scenarios
  task automatic test_reset();
    set_id(2, 3, 1, 1, 1, 4, 1, 0);
    brtaken = 0; imemready = 1; memready = 1;
    resetn = 0;
    #2;
    checks++;
    if ({stallif, stallid, bubbleex, flushid, memreq, freeze, fwda, fwdb} !== 10'b0) begin
      errors++;
      $display("FAIL reset_ctrl actual=%b required=%b",
               {stallif, stallid, bubbleex, flushid, memreq, freeze, fwda, fwdb}, 10'b0);
    end
    next();
    checks++;
    if (stallcnt !== 16'd0 || dut.state !== RUN) begin
      errors++;
      $display("FAIL reset_state actual cnt=%0d state=%0d required cnt=0 state=0",
               stallcnt, dut.state);
    end
    resetn = 1;
    set_nop();
    #1;
    checks++;
    if ({stallif, memreq, freeze, fwda, fwdb} !== 7'b0) begin
      errors++;
      $display("FAIL post_reset_ctrl actual=%b required=%b",
               {stallif, memreq, freeze, fwda, fwdb}, 7'b0);
    end
    next();
  endtask

  task automatic test_stallcnt();
    do_reset();
    imemready = 0;
    #1;
    checks++;
    if ({stallif, stallid, bubbleex, flushid} !== 4'b1110) begin
      errors++;
      $display("FAIL imiss_ctrl actual=%b required=%b",
               {stallif, stallid, bubbleex, flushid}, 4'b1110);
    end
    next();
    next();
    imemready = 1;
    #1;
    checks++;
    if (stallcnt !== 16'd2) begin
      errors++;
      $display("FAIL stallcnt_two actual=%0d required=2", stallcnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    push(1, 0, 1, 0, 1, 2, 1, 0);                 // LW $2
    set_id(2, 4, 1, 1, 1, 3, 0, 0);               // ADD $3,$2,$4
    #1;
    checks++;
    if ({stallif, stallid, bubbleex, flushid} !== 4'b1110) begin
      errors++;
      $display("FAIL loaduse_stall actual=%b required=%b",
               {stallif, stallid, bubbleex, flushid}, 4'b1110);
    end
    next();
    #1;
    checks++;
    if ({stallif, stallid, bubbleex} !== 3'b000) begin
      errors++;
      $display("FAIL loaduse_once actual=%b required=%b",
               {stallif, stallid, bubbleex}, 3'b000);
    end
    next();
    set_nop();
    #1;
    checks++;
    if (fwda !== FWD_WB || fwdb !== FWD_REG) begin
      errors++;
      $display("FAIL loaduse_fwd actual fwda=%b fwdb=%b required fwda=10 fwdb=00",
               fwda, fwdb);
    end
  endtask

  task automatic test_forward();
    do_reset();
    push(0, 0, 0, 0, 1, 5, 0, 0);                 // SUB $5
    push(0, 0, 0, 0, 1, 5, 0, 0);                 // ADD $5
    push(5, 5, 1, 1, 0, 0, 0, 0);                 // reader of $5
    set_nop();
    #1;
    checks++;
    if (fwda !== FWD_MEM || fwdb !== FWD_MEM) begin
      errors++;
      $display("FAIL fwd_mem_wins actual fwda=%b fwdb=%b required 01/01", fwda, fwdb);
    end
    push(0, 0, 0, 0, 1, 0, 0, 0);                 // writes $0
    push(0, 0, 0, 0, 1, 0, 0, 0);                 // writes $0
    push(0, 0, 1, 1, 0, 0, 0, 0);                 // reads $0
    set_nop();
    #1;
    checks++;
    if (fwda !== FWD_REG || fwdb !== FWD_REG) begin
      errors++;
      $display("FAIL fwd_reg0 actual fwda=%b fwdb=%b required 00/00", fwda, fwdb);
    end
    push(1, 0, 1, 0, 1, 6, 1, 0);                 // LW $6
    push(6, 9, 0, 0, 0, 0, 0, 0);                 // names $6 without using it
    set_nop();
    #1;
    checks++;
    if (fwda !== FWD_REG) begin
      errors++;
      $display("FAIL fwd_no_load_mem actual fwda=%b required 00", fwda);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    push(1, 2, 1, 1, 0, 0, 0, 1);                 // SW
    push(0, 0, 0, 0, 1, 3, 0, 0);                 // ADD $3
    set_id(3, 0, 1, 0, 0, 0, 0, 0);               // reader of $3
    memready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({memreq, freeze, stallif, stallid, bubbleex, flushid} !== 6'b111100) begin
        errors++;
        $display("FAIL memwait_ctrl cyc=%0d actual=%b required=%b", i,
                 {memreq, freeze, stallif, stallid, bubbleex, flushid}, 6'b111100);
      end
      if (i > 0) begin
        checks++;
        if (dut.state !== MEMWAIT) begin
          errors++;
          $display("FAIL memwait_state cyc=%0d actual=%0d required=%0d", i, dut.state, MEMWAIT);
        end
      end
      next();
    end
    memready = 1;
    #1;
    checks++;
    if ({memreq, freeze, stallif} !== 3'b100 || dut.state !== MEMWAIT) begin
      errors++;
      $display("FAIL memwait_release actual=%b state=%0d required=100 state=1",
               {memreq, freeze, stallif}, dut.state);
    end
    next();
    set_nop();
    #1;
    checks++;
    if (memreq !== 1'b0 || fwda !== FWD_MEM || dut.state !== RUN) begin
      errors++;
      $display("FAIL memwait_advance actual memreq=%b fwda=%b state=%0d required 0/01/0",
               memreq, fwda, dut.state);
    end
  endtask

  task automatic test_branch();
    do_reset();
    push(1, 0, 1, 0, 1, 2, 1, 0);                 // LW $2
    set_id(2, 0, 1, 0, 1, 3, 0, 0);               // dependent ADD
    brtaken = 1;
    #1;
    checks++;
    if ({flushid, bubbleex, stallif, stallid} !== 4'b1100) begin
      errors++;
      $display("FAIL branch_ctrl actual=%b required=%b",
               {flushid, bubbleex, stallif, stallid}, 4'b1100);
    end
    next();
    brtaken = 0;
    #1;
    checks++;
    if ({stallif, bubbleex, flushid} !== 3'b000) begin
      errors++;
      $display("FAIL branch_nostall actual=%b required=000", {stallif, bubbleex, flushid});
    end
  endtask

  task automatic test_reset_memwait();
    do_reset();
    push(0, 0, 0, 0, 1, 7, 0, 0);                 // ADD $7
    push(1, 2, 1, 1, 0, 0, 0, 1);                 // SW
    push(7, 7, 1, 1, 0, 0, 0, 0);                 // reader of $7
    set_nop();
    memready = 0;
    next();
    checks++;
    if (dut.state !== MEMWAIT || fwda !== FWD_WB || freeze !== 1'b1) begin
      errors++;
      $display("FAIL rstwait_setup actual state=%0d fwda=%b freeze=%b required 1/10/1",
               dut.state, fwda, freeze);
    end
    #2;
    resetn = 0;
    #1;
    checks++;
    if ({memreq, freeze, fwda, fwdb} !== 6'b0 || dut.state !== RUN) begin
      errors++;
      $display("FAIL rstwait_abandon actual=%b state=%0d required=000000 state=0",
               {memreq, freeze, fwda, fwdb}, dut.state);
    end
    @(posedge clock);
    #1;
    resetn = 1;
    memready = 1;
    model_reset();
  endtask

  task automatic test_random();
    bit [9:0] act, exp;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_id(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));
      brtaken   = ($urandom_range(0, 7) == 0);
      imemready = ($urandom_range(0, 7) != 0);
      memready  = ($urandom_range(0, 3) != 0);
      #1;
      model_eval();
      act = {stallif, stallid, bubbleex, flushid, memreq, freeze, fwda, fwdb};
      exp = {e_si, e_sd, e_bub, e_fl, e_memreq, e_freeze, e_fwda, e_fwdb};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL random_ctrl cyc=%0d actual=%b required=%b", i, act, exp);
      end
      checks++;
      if (stallcnt !== 16'(mcnt) || (dut.state == MEMWAIT) !== mwait) begin
        errors++;
        $display("FAIL random_state cyc=%0d actual cnt=%0d wait=%b required cnt=%0d wait=%b",
                 i, stallcnt, (dut.state == MEMWAIT), mcnt, mwait);
      end
      @(posedge clock);
      model_clock();
      #1;
    end
    memready = 1;
    brtaken = 0;
    imemready = 1;
  endtask

  task automatic test_saturate();
    do_reset();
    imemready = 0;
    for (int i = 0; i < 70000; i++) @(posedge clock);
    #1;
    checks++;
    if (stallcnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL stallcnt_saturate actual=%h required=ffff", stallcnt);
    end
    imemready = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 0;
    set_nop();
    brtaken = 0; imemready = 1; memready = 1;
    model_reset();
    #2;
    test_reset();
    test_stallcnt();
    test_load_use();
    test_forward();
    test_mem_wait();
    test_branch();
    test_reset_memwait();
    test_random();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
